// File: rtl/mem_arbiter_if.sv
// picorv32-style native memory port. The master side issues requests and
// receives ready/rdata; the slave side answers them.
interface mem_arbiter_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );
  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter onto one native memory port, one transaction in flight.
// Optional MEM_ARB_TIMEOUT_EN adds a BUSY watchdog and the sticky timeout_err output.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  m0,
  mem_arbiter_if.slave  m1,
  mem_arbiter_if.master s,
  output logic          grant_owner
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic          timeout_err
`endif
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nxt;
  logic   rr_next;
  logic   grant, pick;
  logic   done, tmo;

  // Contention goes to rr_next; otherwise whoever is asking.
  assign grant = m0.mem_valid | m1.mem_valid;
  assign pick  = (m0.mem_valid && m1.mem_valid) ? rr_next : m1.mem_valid;
  assign done  = (state == BUSY) && (s.mem_ready || tmo);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = BUSY;
      BUSY:    if (done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured at grant and then frozen until completion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s.mem_valid <= 1'b0;
      s.mem_instr <= 1'b0;
      s.mem_addr  <= 32'h0;
      s.mem_wdata <= 32'h0;
      s.mem_wstrb <= 4'h0;
      grant_owner <= 1'b0;
      rr_next     <= 1'b0;
    end else if (state == IDLE && grant) begin
      s.mem_valid <= 1'b1;
      s.mem_instr <= pick ? m1.mem_instr : m0.mem_instr;
      s.mem_addr  <= pick ? m1.mem_addr  : m0.mem_addr;
      s.mem_wdata <= pick ? m1.mem_wdata : m0.mem_wdata;
      s.mem_wstrb <= pick ? m1.mem_wstrb : m0.mem_wstrb;
      grant_owner <= pick;
    end else if (done) begin
      s.mem_valid <= 1'b0;
      s.mem_wstrb <= 4'h0;
      rr_next     <= ~grant_owner;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;

  // Fires on the TIMEOUT_CYCLES-th BUSY cycle; a real ready that cycle wins.
  assign tmo = (state == BUSY) && !s.mem_ready && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt     <= 16'h0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE && grant)  tmo_cnt <= 16'h0;
      else if (state == BUSY && !done) tmo_cnt <= tmo_cnt + 16'h1;
      if (tmo) timeout_err <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // Ready is suppressed during reset so an abandoned transaction never completes.
  assign m0.mem_ready = reset && done && !grant_owner;
  assign m1.mem_ready = reset && done &&  grant_owner;
  assign m0.mem_rdata = (tmo && !grant_owner) ? 32'h0 : s.mem_rdata;
  assign m1.mem_rdata = (tmo &&  grant_owner) ? 32'h0 : s.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; timeout cases build only with MEM_ARB_TIMEOUT_EN.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic grant_owner;
`ifdef MEM_ARB_TIMEOUT_EN
  logic timeout_err;
`endif

  mem_arbiter_if m0_if ();
  mem_arbiter_if m1_if ();
  mem_arbiter_if s_if ();

  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .m0          (m0_if),
    .m1          (m1_if),
    .s           (s_if),
    .grant_owner (grant_owner)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    m0_if.mem_valid = 0; m0_if.mem_instr = 0; m0_if.mem_addr = 0; m0_if.mem_wdata = 0; m0_if.mem_wstrb = 0;
    m1_if.mem_valid = 0; m1_if.mem_instr = 0; m1_if.mem_addr = 0; m1_if.mem_wdata = 0; m1_if.mem_wstrb = 0;
    s_if.mem_ready = 0; s_if.mem_rdata = 0;
    tick(); tick();

    // reset state
    chk("rst_s_valid", 32'(s_if.mem_valid), 0);
    chk("rst_s_addr",  s_if.mem_addr, 0);
    chk("rst_s_wstrb", 32'(s_if.mem_wstrb), 0);
    chk("rst_owner",   32'(grant_owner), 0);
    chk("rst_m0_rdy",  32'(m0_if.mem_ready), 0);
    reset = 1'b1;

    // single m0 read: request at cycle 0, slave ready at cycle 3
    m0_if.mem_valid = 1; m0_if.mem_addr = 32'h100; m0_if.mem_wstrb = 4'h0;
    tick();
    chk("rd_s_valid", 32'(s_if.mem_valid), 1);
    chk("rd_s_addr",  s_if.mem_addr, 32'h100);
    chk("rd_owner",   32'(grant_owner), 0);
    tick();
    chk("rd_wait_rdy", 32'(m0_if.mem_ready), 0);
    tick();
    s_if.mem_ready = 1; s_if.mem_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_m0_rdy",   32'(m0_if.mem_ready), 1);
    chk("rd_m0_rdata", m0_if.mem_rdata, 32'hDEADBEEF);
    chk("rd_m1_rdy",   32'(m1_if.mem_ready), 0);
    tick();
    s_if.mem_ready = 0; m0_if.mem_valid = 0;
    chk("rd_done_valid", 32'(s_if.mem_valid), 0);
    tick();

    // simultaneous requests: m0 first, then m1 write
    do_reset();
    m0_if.mem_valid = 1; m0_if.mem_addr = 32'h10; m0_if.mem_wstrb = 4'h0;
    m1_if.mem_valid = 1; m1_if.mem_addr = 32'h20; m1_if.mem_wdata = 32'h55AA; m1_if.mem_wstrb = 4'hF;
    tick();
    chk("sim_owner0", 32'(grant_owner), 0);
    chk("sim_addr0",  s_if.mem_addr, 32'h10);
    s_if.mem_ready = 1; s_if.mem_rdata = 32'h1111;
    #1;
    chk("sim_m0_rdy", 32'(m0_if.mem_ready), 1);
    chk("sim_m1_rdy0", 32'(m1_if.mem_ready), 0);
    tick();
    s_if.mem_ready = 0; m0_if.mem_valid = 0;
    chk("sim_gap", 32'(s_if.mem_valid), 0);
    tick();
    chk("sim_owner1", 32'(grant_owner), 1);
    chk("sim_addr1",  s_if.mem_addr, 32'h20);
    chk("sim_wdata1", s_if.mem_wdata, 32'h55AA);
    chk("sim_wstrb1", 32'(s_if.mem_wstrb), 32'hF);
    m0_if.mem_valid = 1; m0_if.mem_addr = 32'h30;
    tick();
    chk("sim_m0_norespond", 32'(m0_if.mem_ready), 0);
    s_if.mem_ready = 1;
    #1;
    chk("sim_m1_rdy",  32'(m1_if.mem_ready), 1);
    chk("sim_m0_rdy1", 32'(m0_if.mem_ready), 0);
    tick();
    s_if.mem_ready = 0; m1_if.mem_valid = 0;
    chk("sim_wstrb_clr", 32'(s_if.mem_wstrb), 0);
    tick();
    chk("sim_m0_regrant", s_if.mem_addr, 32'h30);
    s_if.mem_ready = 1;
    tick();
    s_if.mem_ready = 0; m0_if.mem_valid = 0;
    tick();

    // fairness: both held valid, rr_next reset to m0
    do_reset();
    m0_if.mem_valid = 1; m1_if.mem_valid = 1;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 5 && !s_if.mem_valid; k++) tick();
      chk($sformatf("fair_valid%0d", i), 32'(s_if.mem_valid), 1);
      chk($sformatf("fair_owner%0d", i), 32'(grant_owner), 32'(i % 2));
      s_if.mem_ready = 1;
      #1;
      chk($sformatf("fair_rdy%0d", i),
          32'((i % 2) ? m1_if.mem_ready : m0_if.mem_ready), 1);
      tick();
      s_if.mem_ready = 0;
    end
    m0_if.mem_valid = 0; m1_if.mem_valid = 0;
    tick();

    // stable fields: m1 changes addr while busy
    m1_if.mem_valid = 1; m1_if.mem_addr = 32'h40; m1_if.mem_wstrb = 4'h3;
    tick();
    chk("stab_addr_a", s_if.mem_addr, 32'h40);
    m1_if.mem_addr = 32'h80; m1_if.mem_wstrb = 4'hC;
    tick();
    chk("stab_addr_b", s_if.mem_addr, 32'h40);
    chk("stab_wstrb",  32'(s_if.mem_wstrb), 32'h3);
    s_if.mem_ready = 1;
    #1;
    chk("stab_rdy", 32'(m1_if.mem_ready), 1);
    tick();
    s_if.mem_ready = 0; m1_if.mem_valid = 0;
    tick();

    // reset mid-BUSY with m1 owning
    m1_if.mem_valid = 1; m1_if.mem_addr = 32'h200;
    tick();
    chk("rmid_owner1", 32'(grant_owner), 1);
    reset = 1'b0; s_if.mem_ready = 1;
    #1;
    chk("rmid_m1_rdy", 32'(m1_if.mem_ready), 0);
    chk("rmid_m0_rdy", 32'(m0_if.mem_ready), 0);
    tick();
    chk("rmid_valid", 32'(s_if.mem_valid), 0);
    chk("rmid_owner", 32'(grant_owner), 0);
    chk("rmid_m1_rdy2", 32'(m1_if.mem_ready), 0);
    reset = 1'b1; s_if.mem_ready = 0; m1_if.mem_valid = 0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // timeout: slave never ready, fires on 4th BUSY cycle
    m0_if.mem_valid = 1; m0_if.mem_addr = 32'h300; s_if.mem_rdata = 32'h12345678;
    tick();
    tick(); tick();
    chk("tmo_early", 32'(m0_if.mem_ready), 0);
    tick();
    chk("tmo_rdy",   32'(m0_if.mem_ready), 1);
    chk("tmo_rdata", m0_if.mem_rdata, 0);
    tick();
    m0_if.mem_valid = 0;
    chk("tmo_err",   32'(timeout_err), 1);
    chk("tmo_valid", 32'(s_if.mem_valid), 0);
    tick(); tick();
    chk("tmo_sticky", 32'(timeout_err), 1);

    // ready on the 4th BUSY cycle wins over the timeout
    do_reset();
    m1_if.mem_valid = 1;
    tick();
    tick(); tick(); tick();
    s_if.mem_ready = 1; s_if.mem_rdata = 32'hCAFE;
    #1;
    chk("tmo_race_rdy",   32'(m1_if.mem_ready), 1);
    chk("tmo_race_rdata", m1_if.mem_rdata, 32'hCAFE);
    tick();
    s_if.mem_ready = 0; m1_if.mem_valid = 0;
    chk("tmo_race_err", 32'(timeout_err), 0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing one picorv32-style native memory port (valid/ready, addr/wdata/wstrb/rdata, instr flag).
- Sits between requesters (m0: CPU core, m1: debug/DMA loader) and the single memory or bus slave.
- Round-robin fairness; one outstanding transaction at a time; request fields registered toward the slave.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles a granted transaction waits for s_mem_ready; used only with MEM_ARB_TIMEOUT_EN; legal range 1..65535.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- m0_mem_valid  input  1  requester 0 request
- m0_mem_instr  input  1  requester 0 instruction-fetch flag
- m0_mem_addr  input  32  requester 0 byte address
- m0_mem_wdata  input  32  requester 0 write data
- m0_mem_wstrb  input  4  requester 0 byte strobes (0000 = read)
- m0_mem_ready  output  1  requester 0 completion pulse
- m0_mem_rdata  output  32  requester 0 read data
- m1_* (same six signals)  same  same  requester 1
- s_mem_valid  output  1  slave request
- s_mem_instr  output  1  slave instruction flag
- s_mem_addr  output  32  slave address
- s_mem_wdata  output  32  slave write data
- s_mem_wstrb  output  4  slave strobes
- s_mem_ready  input  1  slave completion
- s_mem_rdata  input  32  slave read data
- grant_owner  output  1  index of current or last owner
- timeout_err  output  1  sticky timeout flag (present only with MEM_ARB_TIMEOUT_EN)

Behaviour:
- Reset (reset==0 at posedge): state IDLE; s_mem_valid=0, s_mem_instr=0, s_mem_addr=0, s_mem_wdata=0, s_mem_wstrb=0; grant_owner=0; rr_next=0 (m0 preferred); timeout counter=0; timeout_err=0. m*_mem_ready is 0 throughout reset.
- Reset mid-transaction: transaction is abandoned, no ready pulse is issued, and the slave sees s_mem_valid=0 on the next cycle.
- States:
  - IDLE: if no m*_mem_valid, stay in IDLE. If exactly one is valid, grant it. If both are valid, grant rr_next. On grant, register the owner's instr/addr/wdata/wstrb onto s_*, set s_mem_valid=1, set grant_owner=owner, go to BUSY. Request seen in cycle N produces s_mem_valid=1 in cycle N+1.
  - BUSY: s_* fields are held stable. Requester inputs are ignored, including changes by the owner. When s_mem_ready=1:
    - the owner's m_mem_ready=1 in the same cycle (combinational) and its m_mem_rdata=s_mem_rdata;
    - next edge: s_mem_valid=0, s_mem_wstrb=0, rr_next=~owner, state IDLE.
- Non-owner's m_mem_ready is always 0. m*_mem_rdata = s_mem_rdata at all times; it is only qualified by ready.
- s_mem_ready while s_mem_valid=0 (IDLE) is ignored.
- Minimum transaction: 1 IDLE cycle + 1 BUSY cycle. Back-to-back grants are separated by one IDLE cycle.
- A master that keeps m_mem_valid high in the cycle after its ready is re-arbitrated as a new request. This is legal, but it loses priority to a pending other master.
- Starvation bound: a waiting requester is granted after at most one transaction of the other requester.
- m_mem_valid dropped by a waiting (ungranted) requester is simply not granted. No state is kept.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on grant and increments each BUSY cycle without s_mem_ready.
  - When it reaches TIMEOUT_CYCLES with s_mem_ready=0, that cycle the owner's m_mem_ready=1 and m_mem_rdata=32'h0 (override).
  - On the next edge, timeout_err is set to 1 (sticky until reset), s_mem_valid=0, and the arbiter returns to IDLE with rr_next flipped.
  - If s_mem_ready and the timeout coincide, s_mem_ready wins: normal completion, no error.
- Undefined: no counter and no timeout_err port; BUSY waits indefinitely.

Test Plan:
- Single m0 read: m0 valid, addr=0x100, wstrb=0 at cycle 0 -> s_mem_valid=1, s_mem_addr=0x100 at cycle 1. Slave ready with rdata=0xDEADBEEF at cycle 3 -> m0_mem_ready=1, m0_mem_rdata=0xDEADBEEF at cycle 3; s_mem_valid=0 at cycle 4.
- Simultaneous requests after reset: m0 addr=0x10, m1 addr=0x20 write wdata=0x55AA, wstrb=1111 -> m0 served first. Then m1 is granted with s_mem_addr=0x20, s_mem_wdata=0x55AA, s_mem_wstrb=1111; grant_owner=1. m0 never sees ready during m1's transaction.
- Fairness: both held continuously valid for 6 transactions -> grant order 0,1,0,1,0,1.
- Reset mid-BUSY: reset=0 while s_mem_valid=1 -> next cycle s_mem_valid=0, grant_owner=0, no ready pulse to either master.
- Stable fields: m1 changes addr from 0x40 to 0x80 during its BUSY -> s_mem_addr stays 0x40 until completion.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): slave never ready -> owner ready with rdata=0 after 4 BUSY cycles; timeout_err=1 and stays 1. Same run with slave ready on the 4th BUSY cycle -> normal rdata, timeout_err=0.
